// File: rtl/connect_fork.sv
// Routes one valid/ready input stream to CONNECT_NUM independent output channels,
// each backed by a 2-entry FIFO; out-of-range destinations are discarded and flagged on DROP.

module connect_fork_chan #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_full
);
  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_cnt;
  logic                  w_push;
  logic                  w_pop;

  assign o_valid = (r_cnt != 2'd0);
  assign o_full  = (r_cnt == 2'd2);
  assign o_data  = r_mem[r_rptr];
  // No push while full, even if a pop happens on the same edge.
  assign w_push  = i_push && !o_full;
  assign w_pop   = o_valid && i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop)
        r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

module connect_fork #(
  parameter int DATA_WIDTH  = 32,
  parameter int CONNECT_NUM = 3,
  parameter int DEST_WIDTH  = 2
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              RECEIVE_VALID,
  input  logic [DATA_WIDTH-1:0]             RECEIVE_DATA,
  input  logic [DEST_WIDTH-1:0]             RECEIVE_DEST,
  output logic                              RECEIVE_READY,
  output logic [CONNECT_NUM-1:0]            SEND_VALID,
  output logic [DATA_WIDTH*CONNECT_NUM-1:0] SEND_DATA,
  input  logic [CONNECT_NUM-1:0]            SEND_READY,
  output logic                              DROP
);
  localparam int                  DEST_SPAN = 1 << DEST_WIDTH;
  localparam logic [DEST_WIDTH:0] CN        = CONNECT_NUM[DEST_WIDTH:0];

  logic [CONNECT_NUM-1:0] w_full;
  logic [DEST_SPAN-1:0]   w_full_pad;
  logic                   w_in_range;
  logic                   w_accept;
  logic                   r_drop;

  // Pad the full vector to the whole destination space so any DEST indexes safely.
  always_comb begin
    w_full_pad                  = '0;
    w_full_pad[CONNECT_NUM-1:0] = w_full;
  end

  assign w_in_range    = ({1'b0, RECEIVE_DEST} < CN);
  assign RECEIVE_READY = !w_in_range || !w_full_pad[RECEIVE_DEST];
  assign w_accept      = RECEIVE_VALID && RECEIVE_READY;
  assign DROP          = r_drop;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_drop <= 1'b0;
    else     r_drop <= w_accept && !w_in_range;
  end

  for (genvar i = 0; i < CONNECT_NUM; i++) begin : g_chan
    logic w_push;
    assign w_push = w_accept && w_in_range && (RECEIVE_DEST == DEST_WIDTH'(i));

    connect_fork_chan #(.DATA_WIDTH(DATA_WIDTH)) u_chan (
      .clk     (CLK),
      .rst     (RST),
      .i_push  (w_push),
      .i_data  (RECEIVE_DATA),
      .i_ready (SEND_READY[i]),
      .o_valid (SEND_VALID[i]),
      .o_data  (SEND_DATA[DATA_WIDTH*i +: DATA_WIDTH]),
      .o_full  (w_full[i])
    );
  end
endmodule

// File: tb/tb_connect_fork.sv
// Randomized bench for connect_fork against a queue-per-channel reference model.

module tb_connect_fork;
  localparam int DW = 32;
  localparam int CN = 3;
  localparam int DWD = 2;

  logic           CLK = 1'b0;
  logic           RST;
  logic           RECEIVE_VALID;
  logic [DW-1:0]  RECEIVE_DATA;
  logic [DWD-1:0] RECEIVE_DEST;
  logic           RECEIVE_READY;
  logic [CN-1:0]  SEND_VALID;
  logic [DW*CN-1:0] SEND_DATA;
  logic [CN-1:0]  SEND_READY;
  logic           DROP;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] q [CN][$];
  logic          exp_drop;
  logic          exp_rdy;
  logic [CN-1:0] stall;

  connect_fork #(.DATA_WIDTH(DW), .CONNECT_NUM(CN), .DEST_WIDTH(DWD)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .RECEIVE_VALID (RECEIVE_VALID),
    .RECEIVE_DATA  (RECEIVE_DATA),
    .RECEIVE_DEST  (RECEIVE_DEST),
    .RECEIVE_READY (RECEIVE_READY),
    .SEND_VALID    (SEND_VALID),
    .SEND_DATA     (SEND_DATA),
    .SEND_READY    (SEND_READY),
    .DROP          (DROP)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < CN; i++) begin
      check("send_valid", 64'(SEND_VALID[i]), 64'(q[i].size() != 0));
      if (q[i].size() != 0)
        check("send_data", 64'(SEND_DATA[DW*i +: DW]), 64'(q[i][0]));
    end
    check("drop", 64'(DROP), 64'(exp_drop));
  endtask

  task automatic clear_model();
    for (int i = 0; i < CN; i++) q[i].delete();
    exp_drop = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    RECEIVE_VALID = 1'b0;
    RECEIVE_DATA  = '0;
    RECEIVE_DEST  = '0;
    SEND_READY    = '0;
    stall         = '0;
    clear_model();
    repeat (3) @(posedge CLK);
    #1;
    check("rst_valid", 64'(SEND_VALID), 64'd0);
    check("rst_drop", 64'(DROP), 64'd0);
    check("rst_data", 64'(SEND_DATA[63:0]), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    for (int d = 0; d < 4; d++) begin
      RECEIVE_DEST = DWD'(d);
      #1;
      check("ready_after_rst", 64'(RECEIVE_READY), 64'd1);
    end

    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      check_outputs();
      if (c % 40 == 0) stall = CN'($urandom_range(0, 7));
      RECEIVE_VALID = ($urandom_range(0, 3) != 0);
      RECEIVE_DATA  = $urandom;
      RECEIVE_DEST  = DWD'($urandom_range(0, 3));
      SEND_READY    = CN'($urandom) & ~stall;
      #1;
      exp_rdy = (RECEIVE_DEST >= CN) || (q[RECEIVE_DEST].size() < 2);
      check("recv_ready", 64'(RECEIVE_READY), 64'(exp_rdy));
      // Model state after the coming edge: pops, then push if accepted.
      for (int i = 0; i < CN; i++)
        if (q[i].size() != 0 && SEND_READY[i]) void'(q[i].pop_front());
      exp_drop = RECEIVE_VALID && exp_rdy && (RECEIVE_DEST >= CN);
      if (RECEIVE_VALID && exp_rdy && RECEIVE_DEST < CN)
        q[RECEIVE_DEST].push_back(RECEIVE_DATA);
      @(posedge CLK);
      if (c % 700 == 350) begin
        #2;
        RST = 1'b1;
        #1;
        check("async_rst_valid", 64'(SEND_VALID), 64'd0);
        check("async_rst_drop", 64'(DROP), 64'd0);
        clear_model();
        @(posedge CLK);
        #1;
        check("rst_hold_valid", 64'(SEND_VALID), 64'd0);
        #1;
        RST = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
